// File: rtl/xaui_rx_pkg.sv
// Shared types and constants for the XAUI single-lane receive word aligner.
package xaui_rx_pkg;

  typedef enum logic [2:0] {
    LOSS_OF_SYNC,
    CD1,
    CD2,
    CD3,
    SYNC_ACQUIRED
  } rx_state_e;

  localparam int unsigned CG_W      = 10;
  localparam int unsigned COMMA_POS = 6;

  // Comma patterns written oldest bit first (MSB = first bit on the wire).
  localparam logic [6:0] K28P5_COMMA_N = 7'b0011111;
  localparam logic [6:0] K28P5_COMMA_P = 7'b1100000;

  // seq[0] is the oldest bit; reversed so it lines up with the constants above.
  function automatic logic comma_match(input logic [COMMA_POS:0] seq);
    logic [COMMA_POS:0] r;
    for (int unsigned i = 0; i <= COMMA_POS; i++) r[i] = seq[COMMA_POS - i];
    return (r == K28P5_COMMA_N) || (r == K28P5_COMMA_P);
  endfunction

endpackage

// File: rtl/xaui_word_check.sv
// Combinational code-group qualifier: aligned comma detect and bad-word decode.
module xaui_word_check
  import xaui_rx_pkg::*;
(
  input  logic [CG_W-1:0] word,
  input  logic            misalign,
  output logic            is_comma,
  output logic            is_bad
);

  logic [3:0] ones;

  always_comb begin
    ones = '0;
    for (int unsigned i = 0; i < CG_W; i++) ones = ones + 4'(word[i]);
  end

  assign is_comma = comma_match(word[COMMA_POS:0]);
  assign is_bad   = misalign || (ones < 4'd4) || (ones > 4'd6);

endmodule

// File: rtl/xaui_lane_rx_align.sv
// Single-lane XAUI receive aligner: comma hunt, code-group lock, sync FSM and
// aligned word delivery with a one-cycle valid strobe.
module xaui_lane_rx_align
  import xaui_rx_pkg::*;
#(
  parameter int unsigned BAD_LIMIT = 4,
  parameter int unsigned ERR_W     = 16
) (
  input  logic             xaui_clk,
  input  logic             reset,
  input  logic             rx_bit,
  input  logic             rx_en,
  output logic [CG_W-1:0]  rx_word,
  output logic             rx_word_vld,
  output logic             rx_comma,
  output logic             rx_sync,
  output logic [ERR_W-1:0] rx_err_cnt
);

  localparam int unsigned BR_W = $clog2(BAD_LIMIT + 1);

  rx_state_e        st, st_n;
  logic [3:0]       cnt, cnt_n;
  // Nine previous bits; together with the live rx_bit they form the 10-bit window.
  logic [CG_W-2:0]  win, win_n;
  logic [CG_W-1:0]  cur_word, word_n;
  logic             sticky, sticky_n;
  logic             vld_n, comma_n;
  logic [BR_W-1:0]  bad_run, bad_run_n;
  logic [ERR_W-1:0] err_n;
  logic             boundary, comma_det, is_comma, is_bad;

  assign cur_word  = {rx_bit, win};
  assign boundary  = (cnt == 4'(CG_W - 1));
  assign comma_det = comma_match({rx_bit, win[CG_W-2:CG_W-2-(COMMA_POS-1)]});
  assign rx_sync   = (st == SYNC_ACQUIRED);

  xaui_word_check u_check (
    .word     (cur_word),
    .misalign (sticky),
    .is_comma (is_comma),
    .is_bad   (is_bad)
  );

  always_ff @(posedge xaui_clk or posedge reset) begin
    if (reset) begin
      st          <= LOSS_OF_SYNC;
      cnt         <= '0;
      win         <= '0;
      sticky      <= 1'b0;
      bad_run     <= '0;
      rx_err_cnt  <= '0;
      rx_word     <= '0;
      rx_word_vld <= 1'b0;
      rx_comma    <= 1'b0;
    end else begin
      st          <= st_n;
      cnt         <= cnt_n;
      win         <= win_n;
      sticky      <= sticky_n;
      bad_run     <= bad_run_n;
      rx_err_cnt  <= err_n;
      rx_word     <= word_n;
      rx_word_vld <= vld_n;
      rx_comma    <= comma_n;
    end
  end

  always_comb begin
    st_n      = st;
    cnt_n     = cnt;
    win_n     = win;
    sticky_n  = sticky;
    bad_run_n = bad_run;
    err_n     = rx_err_cnt;
    word_n    = rx_word;
    vld_n     = 1'b0;
    comma_n   = 1'b0;
    if (!rx_en) begin
      st_n      = LOSS_OF_SYNC;
      bad_run_n = '0;
      sticky_n  = 1'b0;
    end else begin
      win_n = {rx_bit, win[CG_W-2:1]};
      cnt_n = boundary ? 4'd0 : cnt + 4'd1;
      if (st == LOSS_OF_SYNC) begin
        sticky_n = 1'b0;
        if (comma_det) begin
          cnt_n = 4'(COMMA_POS + 1);
          st_n  = CD1;
        end
      end else if (boundary) begin
        vld_n    = 1'b1;
        word_n   = cur_word;
        comma_n  = is_comma;
        // A comma landing on the boundary cycle is charged to the next word.
        sticky_n = comma_det;
        case (st)
          CD1, CD2, CD3: begin
            if (is_bad) st_n = LOSS_OF_SYNC;
            else if (is_comma) st_n = (st == CD1) ? CD2 : (st == CD2) ? CD3 : SYNC_ACQUIRED;
          end
          SYNC_ACQUIRED: begin
            if (is_bad) begin
              if (rx_err_cnt != '1) err_n = rx_err_cnt + ERR_W'(1);
              if (bad_run + BR_W'(1) == BR_W'(BAD_LIMIT)) begin
                bad_run_n = '0;
                st_n      = LOSS_OF_SYNC;
              end else begin
                bad_run_n = bad_run + BR_W'(1);
              end
            end else begin
              bad_run_n = '0;
            end
          end
          default: st_n = LOSS_OF_SYNC;
        endcase
      end else if (comma_det && (cnt != 4'(COMMA_POS))) begin
        sticky_n = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_xaui_lane_rx_align.sv
// Self-checking bench for xaui_lane_rx_align: directed scenarios plus a random
// mix, all checked cycle by cycle against a bit-history reference model.
module tb_xaui_lane_rx_align;

  localparam int BAD_LIMIT = 4;
  localparam int ERR_W     = 3;
  localparam int ERRMAX    = 7;

  logic             xaui_clk = 1'b0;
  logic             reset    = 1'b1;
  logic             rx_bit   = 1'b0;
  logic             rx_en    = 1'b0;
  logic [9:0]       rx_word;
  logic             rx_word_vld;
  logic             rx_comma;
  logic             rx_sync;
  logic [ERR_W-1:0] rx_err_cnt;

  xaui_lane_rx_align #(.BAD_LIMIT(BAD_LIMIT), .ERR_W(ERR_W)) dut (
    .xaui_clk    (xaui_clk),
    .reset       (reset),
    .rx_bit      (rx_bit),
    .rx_en       (rx_en),
    .rx_word     (rx_word),
    .rx_word_vld (rx_word_vld),
    .rx_comma    (rx_comma),
    .rx_sync     (rx_sync),
    .rx_err_cnt  (rx_err_cnt)
  );

  always #5 xaui_clk = ~xaui_clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int strobes = 0;
  int last_strobe = -1;
  bit chk_space = 0;

  // Reference model: the last 10 enabled bits plus word phase and lock level
  // (0 = hunting, 1..3 = commas still needed, 4 = in sync).
  bit         hist[$];
  int         m_phase, m_level, m_bad, m_err;
  bit         m_mis;
  logic [9:0] e_word;
  bit         e_vld, e_comma, e_sync;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit seq_is_comma(input int start);
    bit [6:0] a;
    for (int i = 0; i < 7; i++) a[6-i] = hist[start+i];
    return (a == 7'b0011111) || (a == 7'b1100000);
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 10; i++) hist.push_back(1'b0);
    m_phase = 0; m_level = 0; m_bad = 0; m_err = 0; m_mis = 0;
    e_word = '0; e_vld = 0; e_comma = 0; e_sync = 0;
  endtask

  task automatic model_step(input bit en, input bit b);
    bit cm, isc, bad;
    int ones;
    logic [9:0] w;
    e_vld = 0; e_comma = 0;
    if (!en) begin
      m_level = 0; m_bad = 0; m_mis = 0; e_sync = 0;
      return;
    end
    hist.push_back(b);
    void'(hist.pop_front());
    cm = seq_is_comma(3);
    if (m_level == 0) begin
      m_mis = 0;
      if (cm) begin m_phase = 7; m_level = 1; end
      else m_phase = (m_phase + 1) % 10;
    end else begin
      if (m_phase == 9) begin
        ones = 0;
        for (int i = 0; i < 10; i++) begin w[i] = hist[i]; ones += int'(hist[i]); end
        isc = seq_is_comma(0);
        bad = (ones < 4) || (ones > 6) || m_mis;
        e_vld = 1; e_word = w; e_comma = isc;
        m_mis = cm;
        if (m_level < 4) begin
          if (bad) m_level = 0;
          else if (isc) m_level++;
        end else if (bad) begin
          if (m_err < ERRMAX) m_err++;
          m_bad++;
          if (m_bad == BAD_LIMIT) begin m_level = 0; m_bad = 0; end
        end else begin
          m_bad = 0;
        end
      end else if (cm && m_phase != 6) begin
        m_mis = 1;
      end
      m_phase = (m_phase + 1) % 10;
    end
    e_sync = (m_level == 4);
  endtask

  task automatic send_bit(input bit b, input bit en);
    @(negedge xaui_clk);
    rx_bit = b; rx_en = en;
    @(posedge xaui_clk);
    cyc++;
    model_step(en, b);
    #1;
    check("vld", rx_word_vld, e_vld);
    check("comma", rx_comma, e_comma);
    check("sync", rx_sync, e_sync);
    check("err", rx_err_cnt, m_err);
    check("word", rx_word, e_word);
    if (rx_word_vld) begin
      strobes++;
      if (chk_space && last_strobe >= 0) check("spacing", cyc - last_strobe, 10);
      last_strobe = cyc;
    end
  endtask

  task automatic send_word(input logic [9:0] w);
    for (int i = 0; i < 10; i++) send_bit(w[i], 1'b1);
  endtask

  task automatic do_reset();
    @(negedge xaui_clk);
    reset = 1; rx_en = 0; rx_bit = 0;
    model_reset();
    #1;
    check("rst_vld", rx_word_vld, 0);
    check("rst_word", rx_word, 0);
    check("rst_comma", rx_comma, 0);
    check("rst_sync", rx_sync, 0);
    check("rst_err", rx_err_cnt, 0);
    @(negedge xaui_clk);
    reset = 0;
    last_strobe = -1;
  endtask

  localparam logic [9:0] K_N = 10'h17C;
  localparam logic [9:0] K_P = 10'h283;

  initial begin
    int s0, r, k;
    logic [9:0] w;

    // A: plain RD- comma stream from reset
    do_reset();
    chk_space = 1;
    send_word(K_N);
    check("a_first_vld", rx_word_vld, 1);
    check("a_first_word", rx_word, 10'h17C);
    check("a_first_comma", rx_comma, 1);
    check("a_sync1", rx_sync, 0);
    send_word(K_N);
    check("a_sync2", rx_sync, 0);
    send_word(K_N);
    check("a_sync3", rx_sync, 1);
    for (int i = 0; i < 3; i++) send_word(K_N);

    // B: partial word aborted by reset, then a 3-bit offset
    for (int i = 0; i < 5; i++) send_bit(K_N[i], 1'b1);
    do_reset();
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)), 1'b1);
    for (int i = 0; i < 6; i++) begin
      send_word(K_N);
      check("b_word", rx_word, 10'h17C);
    end
    check("b_sync", rx_sync, 1);
    chk_space = 0;

    // C: four consecutive bad words while in sync
    do_reset();
    for (int i = 0; i < 4; i++) send_word(K_N);
    for (int i = 1; i <= 4; i++) begin
      send_word(10'h000);
      check("c_err", rx_err_cnt, i);
      check("c_sync", rx_sync, (i < 4) ? 1 : 0);
    end

    // D: bad run broken by one good word
    do_reset();
    for (int i = 0; i < 4; i++) send_word(K_N);
    for (int i = 0; i < 3; i++) send_word(10'h000);
    send_word(10'h2AA);
    for (int i = 0; i < 3; i++) send_word(10'h000);
    check("d_sync", rx_sync, 1);
    check("d_err", rx_err_cnt, 6);

    // E: comma shifted by two bits while in CD2
    do_reset();
    send_word(K_N);
    send_word(10'h1F2);
    check("e_vld", rx_word_vld, 1);
    check("e_word", rx_word, 10'h1F2);
    s0 = strobes;
    send_word(10'h2AA);
    send_word(10'h2AA);
    check("e_nostrobe", strobes - s0, 0);

    // F: lane disabled for 5 cycles while in sync
    do_reset();
    for (int i = 0; i < 4; i++) send_word(K_N);
    send_word(10'h000);
    send_word(K_N);
    check("f_err_pre", rx_err_cnt, 1);
    s0 = strobes;
    send_bit(1'($urandom_range(0, 1)), 1'b0);
    check("f_sync_drop", rx_sync, 0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    check("f_nostrobe", strobes - s0, 0);
    check("f_err_hold", rx_err_cnt, 1);
    for (int i = 0; i < 3; i++) send_word(K_N);
    check("f_resync", rx_sync, 1);
    check("f_err_post", rx_err_cnt, 1);

    // H: error counter saturation
    do_reset();
    for (int i = 0; i < 4; i++) send_word(K_N);
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 3; i++) send_word(10'h000);
      send_word(10'h2AA);
    end
    check("h_sat", rx_err_cnt, 7);
    send_word(10'h000);
    check("h_sat_hold", rx_err_cnt, 7);
    check("h_sync", rx_sync, 1);

    // G: random mix of commas, data, slips and enable drops
    do_reset();
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 3)      send_word(K_N);
      else if (r == 4) send_word(K_P);
      else if (r <= 6) begin w = 10'($urandom); send_word(w); end
      else if (r == 7) send_word(10'h000);
      else if (r == 8) begin
        k = $urandom_range(1, 3);
        for (int i = 0; i < k; i++) send_bit(1'($urandom_range(0, 1)), 1'b1);
      end else begin
        k = $urandom_range(1, 6);
        for (int i = 0; i < k; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/xaui_lane_rx_align.md
# xaui_lane_rx_align

Single-lane XAUI receive word aligner for the ESR behavioural serdes environment. It sits at the serial side of a lane, opposite the serializer that drives `XAUI_TX_P/N`. The block:
- takes one recovered serial bit per `xaui_clk`;
- finds K28.5 commas and locks the 10-bit code-group boundary;
- runs a simplified clause-48-style sync state machine;
- delivers aligned 10-bit code groups with a valid strobe toward the `esr_mac_rxd*` path.

Four instances, one per lane, form a port receiver.

## Interface
Parameters:
- `BAD_LIMIT`, 4: consecutive bad code groups in sync that force loss of sync.
- `ERR_W`, 16: width of the saturating error counter.

Ports:
- `xaui_clk`  in  1  bit clock, one serial bit per rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_bit`  in  1  serial data, already resolved from the P/N pair (P=1 means 1).
- `rx_en`  in  1  lane enable. When 0, the block holds LOSS_OF_SYNC and shifts nothing.
- `rx_word`  out  10  aligned code group. Bit 0 is the first bit received (8b/10b bit a).
- `rx_word_vld`  out  1  one-cycle strobe; `rx_word` is valid in that cycle.
- `rx_comma`  out  1  qualifies `rx_word_vld`: the word is an aligned K28.5 comma.
- `rx_sync`  out  1  high while in SYNC_ACQUIRED.
- `rx_err_cnt`  out  ERR_W  saturating count of bad words seen while in sync.

## Operation
- **Shift window:** a 10-bit window holds the last 10 received bits. The newest bit enters at the top; the oldest bit sits at index 0.
- **Comma detect:** the last 7 received bits, oldest first, equal 0011111 or 1100000.
- **Phase counter:** `cnt` runs 0..9 and advances each enabled cycle. A word boundary is the cycle in which `cnt`==9.

State machine (`st`):
- **LOSS_OF_SYNC:**
  - On comma detect, load `cnt` so the comma bit has `cnt`=6. The word therefore completes 3 cycles later.
  - Go to CD1.
- **CD1, CD2, CD3**, evaluated only at word boundaries:
  - Aligned comma word: advance to CD2, CD3, then SYNC_ACQUIRED.
  - Bad word: go to LOSS_OF_SYNC.
  - Other good word: stay in the current state.
- **SYNC_ACQUIRED:**
  - Bad word: increment `bad_run`; increment `rx_err_cnt`, saturating at all-ones.
  - Good word: clear `bad_run`.
  - When `bad_run` reaches `BAD_LIMIT`, go to LOSS_OF_SYNC and clear `bad_run`.
- **Bad word:** the ones count is not 4, 5 or 6, or a misaligned comma was detected since the last boundary. A misaligned comma is one whose comma bit has `cnt`≠6. It is a sticky flag, cleared at each boundary.
- **Outputs by state:**
  - `rx_word_vld` fires at every boundary in CD1..SYNC_ACQUIRED.
  - No strobes in LOSS_OF_SYNC, except the boundary that completes the initial comma, which is emitted with `rx_comma`=1.
- **rx_en low:**
  - Immediately return to LOSS_OF_SYNC.
  - Clear `bad_run` and the sticky flag.
  - Hold `rx_err_cnt`.
  - Do not shift the window.

## Timing
- **Reset values:** `rx_word`=0, `rx_word_vld`=0, `rx_comma`=0, `rx_sync`=0, `rx_err_cnt`=0. Internally `st`=LOSS_OF_SYNC, `cnt`=0, window=0.
- **Latency:** `rx_word_vld`, `rx_word` and `rx_comma` are registered. They appear the cycle after the 10th bit of the word is sampled.
- **rx_sync:** rises the cycle after the boundary that completes the third aligned comma in CD3. It falls the cycle after the boundary of the `BAD_LIMIT`th consecutive bad word.
- **Strobe spacing:** exactly 10 cycles between strobes while aligned, unless `rx_en` drops.
- **Boundary cases:**
  - A comma that ends exactly on `cnt`==6 in sync is aligned, not an error.
  - A misaligned comma does not realign the counter in CD or SYNC states. Realignment happens only from LOSS_OF_SYNC.
  - A comma detected in the same cycle as a boundary belongs to the next word.
  - When the error counter is saturated, it stays at max.
  - Reset asserted mid-word aborts the word; no partial strobe is produced.

## Structure
- **Package `xaui_rx_pkg`:**
  - state enum (LOSS_OF_SYNC, CD1, CD2, CD3, SYNC_ACQUIRED);
  - constants `K28P5_COMMA_N` = 7'b0011111 and `K28P5_COMMA_P` = 7'b1100000;
  - code-group width 10 and comma position 6.
- **Sub-module `xaui_word_check`:** combinational. Takes a 10-bit word and the sticky misalign flag; produces `is_comma` and `is_bad`.
- **Top level:** the shift window, `cnt`, the state machine and the counters.

## Test plan
- Reset, then a continuous K28.5 RD- stream (0011111010 sent a-first) with `rx_en`=1:
  - first strobe shows `rx_word`=10'h17C with `rx_comma`=1;
  - `rx_sync` rises after the third aligned comma;
  - strobes are every 10 cycles.
- Same stream with 3 leading random bits (arbitrary offset): the block aligns correctly and `rx_word` equals 10'h17C at every strobe.
- Synced, then 4 consecutive words 10'h000:
  - `rx_err_cnt` goes 1, 2, 3, 4;
  - `rx_sync` drops the cycle after the 4th boundary.
- Synced, 3 bad words, 1 good word (10'h2AA), 3 bad words: `rx_sync` stays 1 and `rx_err_cnt`=6.
- In CD2, inject a comma shifted by 2 bits: the next boundary word is bad and the state returns to LOSS_OF_SYNC.
- `rx_en` pulled low for 5 cycles while synced: `rx_sync`=0 the next cycle, no strobes, `rx_err_cnt` is unchanged, and the block reacquires after re-enable.
